// File: rtl/ramp_adc_seq_pkg.sv
// ramp_seq_pkg: shared states and constants for the ramp ADC sequencer
package ramp_seq_pkg;
  typedef enum logic [2:0] {IDLE, PRESET, SETTLE, CONVERT, DONE} state_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int SETTLE_DEFAULT = 4;
endpackage

// File: rtl/ramp_adc_seq_if.sv
// ramp_adc_seq_if: request, counter/front-end and result signals of the sequencer
interface ramp_adc_seq_if #(parameter int WIDTH = 8);
  logic start;
  logic cmp;
  logic ctr_en;
  logic ctr_set;
  logic [WIDTH-1:0] ctr_setval;
  logic [WIDTH-1:0] count;
  logic overflow;
  logic ramp_rst;
  logic busy;
  logic [WIDTH-1:0] result;
  logic result_ovf;
  logic result_valid;
  logic result_ready;
  modport master (
    input  start, cmp, count, overflow, result_ready,
    output ctr_en, ctr_set, ctr_setval, ramp_rst, busy, result, result_ovf, result_valid
  );
  modport slave (
    output start, cmp, count, overflow, result_ready,
    input  ctr_en, ctr_set, ctr_setval, ramp_rst, busy, result, result_ovf, result_valid
  );
endinterface

// File: rtl/ramp_adc_seq_sync_ff.sv
// sync_ff: STAGES-deep synchronizer with asynchronous clear
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s_q, s_d;
  always_comb s_d = {s_q[STAGES-2:0], d};
  always_ff @(posedge clk or posedge rst)
    if (rst) s_q <= '0;
    else s_q <= s_d;
  assign q = s_q[STAGES-1];
endmodule

// File: rtl/ramp_adc_seq.sv
// ramp_adc_seq: single-slope ADC conversion sequencer; RAMP_SEQ_JITTER_EN adds LFSR settle jitter
module ramp_adc_seq
  import ramp_seq_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT,
  parameter int SYNC_STAGES   = 2,
  parameter int CMP_LATENCY   = SYNC_STAGES
) (
  input logic clk,
  input logic rst,
  ramp_adc_seq_if.master io
);
  localparam logic [8:0] SETTLE_LD = 9'(SETTLE_CYCLES - 1);
  state_t state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic ovf_q, ovf_d;
  logic cmp_s;
  logic [2:0] jit;
  logic [WIDTH:0] diff;
  logic [WIDTH-1:0] code;
  sync_ff #(.STAGES(SYNC_STAGES)) u_cmp_sync (.clk(clk), .rst(rst), .d(io.cmp), .q(cmp_s));
`ifdef RAMP_SEQ_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_q <= LFSR_SEED;
    else lfsr_q <= lfsr_d;
  assign jit = lfsr_q[2:0];
`else
  assign jit = '0;
`endif
  // widened subtract so an early trip saturates at zero instead of wrapping
  assign diff = {1'b0, io.count} - (WIDTH+1)'(CMP_LATENCY);
  assign code = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (io.start) begin
        state_d = PRESET;
        cnt_d   = SETTLE_LD + {6'b0, jit};
      end
      PRESET: state_d = SETTLE;
      SETTLE: begin
        state_d = (cnt_q == '0) ? CONVERT : SETTLE;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 9'd1;
      end
      CONVERT: if (cmp_s) begin
        result_d = code;
        ovf_d    = 1'b0;
        state_d  = DONE;
      end else if (io.overflow) begin
        result_d = '1;
        ovf_d    = 1'b1;
        state_d  = DONE;
      end
      DONE: state_d = io.result_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  assign io.ctr_en       = state_q == CONVERT;
  assign io.ctr_set      = state_q == PRESET;
  assign io.ctr_setval   = '0;
  assign io.ramp_rst     = state_q != CONVERT;
  assign io.busy         = state_q != IDLE;
  assign io.result       = result_q;
  assign io.result_ovf   = ovf_q;
  assign io.result_valid = state_q == DONE;
endmodule
